i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C target (slave) responder: the far end of the bus driven by the team's I2C controller core.
//  Oversamples SCL/SDA on the 50 MHz system clock, detects START/STOP, matches a 7-bit address,
//  ACKs, and exchanges bytes with local logic. Write bytes go out on rx_*; read bytes come in on tx_*.
//  SDA is open-drain via sda_oe. No clock stretching; SCL is input only.
// PARAMETERS
//  ADDR        7'h50  own 7-bit target address
//  FILTER_LEN  3      consecutive equal clk samples needed to change a filtered line (spike filter)
// PORTS
//  clk       in   1  system clock, 50 MHz
//  reset     in   1  asynchronous, active-low reset
//  scl_in    in   1  SCL pad input (async)
//  sda_in    in   1  SDA pad input (async)
//  sda_oe    out  1  1 = pull SDA low; 0 = release (pad tri-stated)
//  rx_data   out  8  last byte written by controller; held until next rx_valid
//  rx_valid  out  1  one-clk pulse: rx_data updated
//  tx_data   in   8  byte to return on a read; sampled per tx_req rule below
//  tx_req    out  1  one-clk pulse: supply next tx_data
//  busy      out  1  1 from START to STOP (any address)
//  nack_rcvd out  1  one-clk pulse: controller NACKed a read byte
// BEHAVIOUR
//  Reset (reset=0, async): sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, nack_rcvd=0,
//   state=IDLE, filters preset to 1 (bus idle). Deassertion takes effect on next clk edge.
//  Input path: 2-flop synchronizer, then FILTER_LEN counter filter -> scl_f, sda_f; 1-clk-registered
//   copies give rise/fall strobes. Filter delay provides SDA hold after SCL fall.
//  START = sda_f fall while scl_f=1; STOP = sda_f rise while scl_f=1. Both override any state.
//   START (incl. repeated) -> ADDR, bit count=0, sda_oe=0, busy=1. STOP -> IDLE, sda_oe=0, busy=0.
//  Data bits sampled MSB first on scl_f rise; sda_oe changed only on scl_f fall.
//  States:
//   IDLE     wait for START.
//   ADDR     shift 8 bits (7 addr + R/W). After 8th rise: match -> at next fall sda_oe=1, go AACK;
//            mismatch -> IGNORE (sda_oe stays 0).
//   AACK     R/W=0: at next fall sda_oe=0, go WR. R/W=1: tx_req pulses on this ACK bit's scl rise;
//            at next fall load tx_data into shifter, sda_oe=~bit7, go RD.
//   WR       shift 8 bits; on 8th rise rx_data<=byte, rx_valid=1 the following clk; at next fall
//            sda_oe=1 (always ACK), go WACK. WACK: at next fall sda_oe=0, back to WR.
//   RD       drive bits 6..0 on successive falls; after 8th bit's fall sda_oe=0, go RACK.
//   RACK     sample SDA on rise: 0 -> tx_req pulse same cycle group, at next fall load tx_data, go RD;
//            1 -> nack_rcvd pulse, go IGNORE.
//   IGNORE   sda_oe=0; only START/STOP leave it.
//  tx_data sampled on the scl_f fall following tx_req (half SCL period of slack); must be stable then.
//  STOP/START mid-byte: partial byte discarded, no rx_valid; sda_oe released the same clk.
//  START and STOP never in the same clk (mutually exclusive by SDA edge direction).
//  Bit counter 3 bits, wraps 7->0 at byte end; rx_valid/tx_req/nack_rcvd are exactly 1 clk wide.
//  Filtered pulses shorter than FILTER_LEN clks produce no edge and no state change.
// TESTING
//  1 START, 0xA0, 0x3C, STOP (100 kHz) -> ACK on addr and data; rx_data=8'h3C, one rx_valid, busy 1->0.
//  2 START, 0xA2 (addr 0x51) -> sda_oe never 1; state IGNORE until STOP; no rx_valid.
//  3 START, 0xA1, tx_data=8'hA5 then 8'h5A, ctrl ACK then NACK -> SDA bytes A5,5A; 2 tx_req, 1 nack_rcvd.
//  4 START, 0xA0, 0x11, repeated START, 0xA1 -> rx_data=8'h11, then read phase; busy stays 1.
//  5 STOP after 4 data bits; 1-clk SDA glitch while SCL high -> no rx_valid, no false START/STOP.
//  6 reset=0 mid read byte with sda_oe=1 -> sda_oe=0 immediately (async); IDLE after release.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target responder: oversampled, spike-filtered SCL/SDA, 7-bit address match,
// write bytes out on rx_*, read bytes fetched on tx_*. Open-drain SDA via sda_oe.
module i2c_target #(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_rcvd
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK, S_IGNORE
    } state_t;

    // Index 1 = SCL, index 0 = SDA.
    logic [1:0]         sync1, sync2, filt, filt_d;
    logic [1:0][CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            cnt    <= '0;
        end else begin
            sync1  <= {scl_in, sda_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_rise =  filt[1] & ~filt_d[1];
    assign scl_fall = ~filt[1] &  filt_d[1];
    assign start    = scl_f & ~filt[0] &  filt_d[0];
    assign stop     = scl_f &  filt[0] & ~filt_d[0];

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n, rx_data_n;
    logic       rw, rw_n, byte_done, byte_done_n, sda_oe_n, busy_n;
    logic       rx_valid_n, tx_req_n, nack_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            byte_done <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            nack_rcvd <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            rw        <= rw_n;
            byte_done <= byte_done_n;
            sda_oe    <= sda_oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            tx_req    <= tx_req_n;
            nack_rcvd <= nack_n;
            busy      <= busy_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        rw_n        = rw;
        byte_done_n = byte_done;
        sda_oe_n    = sda_oe;
        rx_data_n   = rx_data;
        busy_n      = busy;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        nack_n      = 1'b0;

        if (start) begin
            state_n     = S_ADDR;
            bit_cnt_n   = '0;
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b1;
        end else if (stop) begin
            state_n     = S_IDLE;
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_WR: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_WR) begin
                                rx_data_n   = {shreg[6:0], sda_f};
                                rx_valid_n  = 1'b1;
                                byte_done_n = 1'b1;
                            end else if (shreg[6:0] == ADDR) begin
                                rw_n        = sda_f;
                                byte_done_n = 1'b1;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        // ACK is driven during the low phase after the 8th bit.
                        byte_done_n = 1'b0;
                        sda_oe_n    = 1'b1;
                        state_n     = (state == S_WR) ? S_WACK : S_AACK;
                    end
                end
                S_AACK: begin
                    if (scl_rise) begin
                        tx_req_n = rw;
                    end else if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            shreg_n  = tx_data;
                            sda_oe_n = ~tx_data[7];
                            state_n  = S_RD;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = S_WR;
                        end
                    end
                end
                S_WACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = S_WR;
                    end
                end
                S_RD: begin
                    // Bit 7 went out on entry; falls 1..7 present bits 6..0, the 8th releases.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = S_RACK;
                        end else begin
                            sda_oe_n  = ~shreg[6];
                            shreg_n   = {shreg[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            tx_req_n = 1'b1;
                        end else begin
                            nack_n  = 1'b1;
                            state_n = S_IGNORE;
                        end
                    end else if (scl_fall) begin
                        shreg_n   = tx_data;
                        sda_oe_n  = ~tx_data[7];
                        bit_cnt_n = '0;
                        state_n   = S_RD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on a wired-AND SDA line,
// with pulse counters on rx_valid / tx_req / nack_rcvd / sda_oe.
module tb_i2c_target;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       scl      = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       sda_line;
    logic       sda_oe, rx_valid, tx_req, busy, nack_rcvd;
    logic [7:0] rx_data;

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target #(.ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy),
        .nack_rcvd (nack_rcvd)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q      = 25;
    int rxv_cnt = 0, txr_cnt = 0, nack_cnt = 0, oe_cnt = 0;

    always @(posedge clk) begin
        if (rx_valid)  rxv_cnt  <= rxv_cnt + 1;
        if (tx_req)    txr_cnt  <= txr_cnt + 1;
        if (nack_rcvd) nack_cnt <= nack_cnt + 1;
        if (sda_oe)    oe_cnt   <= oe_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sda_ctrl = b;
        tick(q);
        scl = 1'b1;
        tick(q);
        if (glitch) begin
            sda_ctrl = 1'b0;
            tick(1);
            sda_ctrl = b;
        end
        tick(q);
        scl = 1'b0;
        tick(q);
    endtask

    task automatic get_bit(output logic b);
        sda_ctrl = 1'b1;
        tick(q);
        scl = 1'b1;
        tick(q);
        b = sda_line;
        tick(q);
        scl = 1'b0;
        tick(q);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit glitch7, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch7 && (i == 7));
        get_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        send_bit(ack, 1'b0);
    endtask

    task automatic start_cond();
        sda_ctrl = 1'b1;
        tick(q);
        scl = 1'b1;
        tick(q);
        sda_ctrl = 1'b0;
        tick(q);
        scl = 1'b0;
        tick(q);
    endtask

    task automatic stop_cond();
        sda_ctrl = 1'b0;
        tick(q);
        scl = 1'b1;
        tick(q);
        sda_ctrl = 1'b1;
        tick(q);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int         rxv0, txr0, nack0, oe0;

        // Reset values
        tick(3);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_nack", nack_rcvd, 1'b0);
        reset = 1'b1;
        tick(5);

        // 1: write 0x3C to 0x50 at 100 kHz
        q = 125;
        rxv0 = rxv_cnt;
        start_cond();
        check("t1_busy_start", busy, 1'b1);
        write_byte(8'hA0, 1'b0, ack);
        check("t1_addr_ack", ack, 1'b0);
        write_byte(8'h3C, 1'b0, ack);
        check("t1_data_ack", ack, 1'b0);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_rx_valid_cnt", rxv_cnt - rxv0, 1);
        stop_cond();
        check("t1_busy_stop", busy, 1'b0);
        q = 25;

        // 2: foreign address 0x51 is ignored
        rxv0 = rxv_cnt;
        oe0  = oe_cnt;
        start_cond();
        write_byte(8'hA2, 1'b0, ack);
        check("t2_addr_nack", ack, 1'b1);
        write_byte(8'h55, 1'b0, ack);
        check("t2_data_nack", ack, 1'b1);
        check("t2_busy", busy, 1'b1);
        stop_cond();
        check("t2_oe_never", oe_cnt - oe0, 0);
        check("t2_no_rx_valid", rxv_cnt - rxv0, 0);
        check("t2_busy_stop", busy, 1'b0);

        // 3: read A5 (ACK) then 5A (NACK)
        txr0  = txr_cnt;
        nack0 = nack_cnt;
        tx_data = 8'hA5;
        start_cond();
        write_byte(8'hA1, 1'b0, ack);
        check("t3_addr_ack", ack, 1'b0);
        tx_data = 8'h5A;
        read_byte(1'b0, d);
        check("t3_byte0", d, 8'hA5);
        read_byte(1'b1, d);
        check("t3_byte1", d, 8'h5A);
        check("t3_tx_req_cnt", txr_cnt - txr0, 2);
        check("t3_nack_cnt", nack_cnt - nack0, 1);
        check("t3_oe_released", sda_oe, 1'b0);
        stop_cond();

        // 4: write 0x11, repeated START, read back C3
        tx_data = 8'hC3;
        start_cond();
        write_byte(8'hA0, 1'b0, ack);
        check("t4_addr_ack", ack, 1'b0);
        write_byte(8'h11, 1'b0, ack);
        check("t4_data_ack", ack, 1'b0);
        check("t4_rx_data", rx_data, 8'h11);
        start_cond();
        check("t4_busy_rstart", busy, 1'b1);
        write_byte(8'hA1, 1'b0, ack);
        check("t4_raddr_ack", ack, 1'b0);
        read_byte(1'b1, d);
        check("t4_read", d, 8'hC3);
        check("t4_busy_read", busy, 1'b1);
        stop_cond();
        check("t4_busy_stop", busy, 1'b0);

        // 5: STOP after 4 data bits; 1-clk SDA glitches while SCL high
        rxv0 = rxv_cnt;
        start_cond();
        write_byte(8'hA0, 1'b0, ack);
        check("t5_addr_ack", ack, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        stop_cond();
        check("t5_partial_no_valid", rxv_cnt - rxv0, 0);
        check("t5_partial_rx_data", rx_data, 8'h11);
        check("t5_partial_busy", busy, 1'b0);
        sda_ctrl = 1'b0;
        tick(1);
        sda_ctrl = 1'b1;
        tick(q);
        check("t5_idle_glitch_busy", busy, 1'b0);
        start_cond();
        write_byte(8'hA0, 1'b0, ack);
        write_byte(8'hF0, 1'b1, ack);
        check("t5_glitch_ack", ack, 1'b0);
        check("t5_glitch_rx_data", rx_data, 8'hF0);
        check("t5_glitch_valid", rxv_cnt - rxv0, 1);
        stop_cond();

        // 6: async reset mid read byte while SDA is pulled low
        tx_data = 8'h00;
        start_cond();
        write_byte(8'hA1, 1'b0, ack);
        check("t6_addr_ack", ack, 1'b0);
        get_bit(b);
        get_bit(b);
        check("t6_oe_before", sda_oe, 1'b1);
        #3 reset = 1'b0;
        #1;
        check("t6_oe_async", sda_oe, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        tick(3);
        reset = 1'b1;
        sda_ctrl = 1'b1;
        tick(q);
        scl = 1'b1;
        tick(2 * q);
        check("t6_busy_idle", busy, 1'b0);
        check("t6_rx_data_rst", rx_data, 8'h00);
        start_cond();
        write_byte(8'hA0, 1'b0, ack);
        check("t6_post_addr_ack", ack, 1'b0);
        write_byte(8'h77, 1'b0, ack);
        check("t6_post_rx_data", rx_data, 8'h77);
        stop_cond();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
